// File: rtl/plca_rx_cmd_decoder.sv
// PLCA receive-side command decoder: qualifies BEACON/COMMIT nibbles signalled with
// RX_ER while RX_DV is low, hides them from the MAC, and drives rx_cmd/receiving.
//
// state      | meaning
// -----------+----------------------------------------------------------
// IDLE       | no command or frame in progress
// CMD_QUAL   | command nibble seen, counting consecutive matching samples
// CMD_ACTIVE | command qualified, rx_cmd presented
// DATA       | PHY_RX_DV high, frame being received
module plca_rx_cmd_decoder #(
    parameter logic [3:0]  BEACON_RXD     = 4'b0010,
    parameter logic [3:0]  COMMIT_RXD     = 4'b0011,
    parameter int unsigned MIN_CMD_CYCLES = 2
) (
    input  logic       RX_CLK,
    input  logic       reset,
    input  logic       plca_en,
    input  logic       PHY_RX_DV,
    input  logic       PHY_RX_ER,
    input  logic [3:0] PHY_RXD,
    input  logic       PHY_CRS,
    output logic       RX_DV,
    output logic       RX_ER,
    output logic [3:0] RXD,
    output logic       CRS,
    output logic [1:0] rx_cmd,
    output logic       receiving,
    output logic       beacon_det,
    output logic [1:0] rx_dec_state
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        CMD_QUAL   = 2'd1,
        CMD_ACTIVE = 2'd2,
        DATA       = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CLS_IDL = 2'd0,
        CLS_DAT = 2'd1,
        CLS_BCN = 2'd2,
        CLS_CMT = 2'd3
    } cls_t;

    localparam logic [1:0] CMD_BEACON = 2'b00;
    localparam logic [1:0] CMD_COMMIT = 2'b01;
    localparam logic [1:0] CMD_NONE   = 2'b10;
    localparam logic [7:0] MIN_CNT    = 8'(MIN_CMD_CYCLES);

    state_t     state, state_nx;
    cls_t       cls;
    logic [7:0] cnt, cnt_nx, cnt_inc;
    logic       cand, cand_nx;          // 1 = COMMIT candidate, 0 = BEACON
    logic [1:0] rx_cmd_nx;
    logic       receiving_nx;
    logic       beacon_det_nx;
    logic       is_cmd, is_dat, cls_cmt;
    logic       start;
    logic       mask;

    always_comb begin
        cls = CLS_IDL;
        if (PHY_RX_DV)
            cls = CLS_DAT;
        else if (PHY_RX_ER && (PHY_RXD == BEACON_RXD))
            cls = CLS_BCN;
        else if (PHY_RX_ER && (PHY_RXD == COMMIT_RXD))
            cls = CLS_CMT;
    end

    assign is_cmd  = (cls == CLS_BCN) || (cls == CLS_CMT);
    assign is_dat  = (cls == CLS_DAT);
    assign cls_cmt = (cls == CLS_CMT);
    assign cnt_inc = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    assign mask    = plca_en && is_cmd;

    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        cand_nx       = cand;
        rx_cmd_nx     = rx_cmd;
        beacon_det_nx = 1'b0;
        start         = 1'b0;
        if (!plca_en) begin
            state_nx  = IDLE;
            cnt_nx    = 8'd0;
            rx_cmd_nx = CMD_NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (is_cmd)
                        start = 1'b1;
                    else if (is_dat)
                        state_nx = DATA;
                end
                CMD_QUAL: begin
                    if (is_cmd && (cls_cmt == cand)) begin
                        cnt_nx = cnt_inc;
                        if (cnt_inc == MIN_CNT) begin
                            state_nx      = CMD_ACTIVE;
                            rx_cmd_nx     = cand ? CMD_COMMIT : CMD_BEACON;
                            beacon_det_nx = !cand;
                        end
                    end else if (is_cmd) begin
                        start = 1'b1;
                    end else begin
                        cnt_nx   = 8'd0;
                        state_nx = is_dat ? DATA : IDLE;
                    end
                end
                CMD_ACTIVE: begin
                    if (!(is_cmd && (cls_cmt == cand))) begin
                        rx_cmd_nx = CMD_NONE;
                        cnt_nx    = 8'd0;
                        if (is_cmd)
                            start = 1'b1;
                        else
                            state_nx = is_dat ? DATA : IDLE;
                    end
                end
                DATA: begin
                    if (is_cmd)
                        start = 1'b1;
                    else if (!is_dat)
                        state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
            // A fresh candidate qualifies immediately when one sample is enough.
            if (start) begin
                cand_nx = cls_cmt;
                cnt_nx  = 8'd1;
                if (MIN_CNT == 8'd1) begin
                    state_nx      = CMD_ACTIVE;
                    rx_cmd_nx     = cls_cmt ? CMD_COMMIT : CMD_BEACON;
                    beacon_det_nx = !cls_cmt;
                end else begin
                    state_nx = CMD_QUAL;
                end
            end
        end
        receiving_nx = plca_en && (state_nx == DATA);
    end

    always_ff @(posedge RX_CLK) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            cand       <= 1'b0;
            rx_cmd     <= CMD_NONE;
            receiving  <= 1'b0;
            beacon_det <= 1'b0;
            RX_DV      <= 1'b0;
            RX_ER      <= 1'b0;
            RXD        <= 4'd0;
            CRS        <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            cand       <= cand_nx;
            rx_cmd     <= rx_cmd_nx;
            receiving  <= receiving_nx;
            beacon_det <= beacon_det_nx;
            RX_DV      <= PHY_RX_DV;
            RX_ER      <= mask ? 1'b0 : PHY_RX_ER;
            RXD        <= mask ? 4'd0 : PHY_RXD;
            CRS        <= PHY_CRS;
        end
    end

    assign rx_dec_state = state;

endmodule

// File: doc/plca_rx_cmd_decoder.md
Name: plca_rx_cmd_decoder

Overview:
- Receive-side counterpart of the PLCA control state diagram's tx_cmd path.
- Sits between the PHY-side MII receive signals and the MAC-side Reconciliation Sublayer.
- Detects PLCA BEACON/COMMIT indications encoded as RX_ER with RX_DV deasserted and qualifies them over consecutive cycles; produces rx_cmd and receiving for the PLCA control state diagram.
- Masks command nibbles so the MAC sees normal inter-frame signalling.

Parameters:
BEACON_RXD, 4'b0010, RXD value (RX_DV=0, RX_ER=1) indicating BEACON
COMMIT_RXD, 4'b0011, RXD value (RX_DV=0, RX_ER=1) indicating COMMIT
MIN_CMD_CYCLES, 2, consecutive matching samples needed to qualify a command; legal range 1..255

Ports:
RX_CLK  in  1  receive clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
plca_en  in  1  PLCA enable; low = transparent pass-through, no command decode
PHY_RX_DV  in  1  RX_DV from PHY
PHY_RX_ER  in  1  RX_ER from PHY
PHY_RXD  in  4  RXD from PHY
PHY_CRS  in  1  CRS from PHY
RX_DV  out  1  RX_DV to MAC
RX_ER  out  1  RX_ER to MAC
RXD  out  4  RXD to MAC
CRS  out  1  registered PHY_CRS
rx_cmd  out  2  BEACON=2'b00, COMMIT=2'b01, NONE=2'b10
receiving  out  1  high while a data frame (PHY_RX_DV) is being received
beacon_det  out  1  one-cycle pulse when a BEACON qualifies
rx_dec_state  out  2  IDLE=0, CMD_QUAL=1, CMD_ACTIVE=2, DATA=3

Behaviour:
- Reset values: every output is 0 except rx_cmd=NONE. State=IDLE, qual counter=0.
- Reset mid-operation takes effect at the next edge regardless of state.
- Per-cycle sample class, evaluated in priority order:
  - DAT: PHY_RX_DV=1, whatever PHY_RX_ER is.
  - BCN: PHY_RX_DV=0, PHY_RX_ER=1, PHY_RXD=BEACON_RXD.
  - CMT: PHY_RX_DV=0, PHY_RX_ER=1, PHY_RXD=COMMIT_RXD.
  - IDL: anything else, including RX_ER with any other RXD value.
- MAC-side outputs: registered, latency 1.
  - RX_DV, RX_ER, RXD and CRS are the previous-cycle PHY values.
  - Exception: when plca_en=1 and the sample class is BCN or CMT, RX_ER=0 and RXD=0.
- Qualification counter: 8 bits, saturates at 255. cand holds the candidate command (BCN or CMT).
- IDLE:
  - BCN/CMT: if MIN_CMD_CYCLES=1, go directly to CMD_ACTIVE; otherwise go to CMD_QUAL with cnt=1 and cand=class.
  - DAT: go to DATA with receiving=1.
  - IDL: stay.
- CMD_QUAL:
  - Same class as cand: cnt+1. When cnt+1 == MIN_CMD_CYCLES, go to CMD_ACTIVE.
  - Other command: restart with cnt=1 and cand=new class.
  - DAT: go to DATA.
  - IDL: go to IDLE with cnt=0.
  - rx_cmd stays NONE throughout.
- Entry into CMD_ACTIVE:
  - rx_cmd is set at the same edge, i.e. the edge sampling the MIN_CMD_CYCLES-th consecutive match.
  - beacon_det=1 for exactly that one cycle when cand=BCN.
- CMD_ACTIVE:
  - While the class equals cand: hold rx_cmd; no further beacon_det pulses.
  - On any other class, at that edge: rx_cmd=NONE, then
    - DAT goes to DATA; this is the normal COMMIT-then-frame case.
    - IDL goes to IDLE.
    - The other command goes to CMD_QUAL with cnt=1.
- DATA:
  - receiving=1 while the class is DAT.
  - On a non-DAT class, receiving=0 at that edge, then:
    - BCN/CMT goes to CMD_QUAL with cnt=1, or directly to CMD_ACTIVE when MIN_CMD_CYCLES=1.
    - IDL goes to IDLE.
- plca_en=0:
  - State is forced to IDLE, rx_cmd=NONE, receiving=0, beacon_det=0.
  - Command samples pass through unmasked.
  - plca_en deasserting mid-command drops rx_cmd at the next edge.
- CRS is a 1-cycle-delayed copy of PHY_CRS, independent of state.
- The counter never wraps; MIN_CMD_CYCLES=255 qualifies on the 255th match.

Test Plan:
1. Reset held 3 cycles with PHY_RX_ER=1, PHY_RXD=4'b0010 -> rx_cmd=2'b10, all other outputs 0, rx_dec_state=0.
2. BEACON nibble (DV=0, ER=1, RXD=4'b0010) for 5 cycles, MIN=2 -> rx_cmd=2'b00 from the 2nd sampled edge; beacon_det high exactly 1 cycle; MAC RX_ER=0, RXD=0; rx_cmd=2'b10 at the edge after the pattern ends.
3. COMMIT 3 cycles, then RX_DV=1 with data 4'h5 for 8 cycles -> rx_cmd=2'b01 for 2 cycles, then NONE; receiving=1 for 8 cycles; MAC RXD=4'h5 one cycle late.
4. Single-cycle BEACON glitch between idles, MIN=2 -> rx_cmd stays NONE, no beacon_det, state returns to IDLE.
5. BEACON 1 cycle then COMMIT 2 cycles, MIN=2 -> restart on COMMIT; rx_cmd=2'b01 at the 2nd COMMIT edge; no beacon_det.
6. plca_en=0 with a 4-cycle BEACON pattern -> rx_cmd=NONE; MAC RX_ER=1, RXD=4'b0010 passed through. Also: reset asserted mid-CMD_ACTIVE -> rx_cmd=NONE and IDLE at the next edge.
